ram_bist_ctrl: RTL and testbench

Parametrised single-port RAM self-test sequencer. It drives a single-port RAM (ena/wea/addr/din/dout style) through a full write pass and a full read-back pass, and compares every read word against the expected pattern. It reports error count, first failing address, pass/fail and a completion pulse. It supersedes the fixed 32-deep, 8-bit, write-then-read driver, adding configurable geometry, read latency, data patterns, looping and self-checking.

---
 rtl/ram_bist_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: single-port RAM self-test sequencer.
// Writes a pattern to every word, reads it back, and counts mismatches.
module ram_bist_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              loop,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  // state | meaning
  // IDLE  | waiting for start
  // WRITE | writing the pattern, one word per cycle
  // READ  | issuing read addresses, one per cycle
  // DRAIN | letting the last reads reach the checker
  // DONE  | one-cycle completion, pass updated
  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [2:0]        DRAIN_LOAD = 3'(RD_LAT);
  localparam logic [31:0]       ALT_ODD    = 32'hAAAA_AAAA;
  localparam logic [31:0]       ALT_EVEN   = 32'h5555_5555;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic [1:0]        m,
                                                input logic [DATA_W-1:0] it);
    logic [DATA_W-1:0] aw;
    aw = DATA_W'(a);
    case (m)
      2'd0:    pattern = aw;
      2'd1:    pattern = ~aw;
      2'd2:    pattern = a[0] ? DATA_W'(ALT_ODD) : DATA_W'(ALT_EVEN);
      default: pattern = aw + it;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   iter_q, iter_d;
  logic [2:0]          drain_cnt_q, drain_cnt_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wr_data_q, ram_wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;

  // Stage 0 holds the read currently on the RAM port; stage RD_LAT is compared.
  logic [RD_LAT:0]     pl_v_q, pl_v_d;
  logic [ADDR_W-1:0]   pl_addr_q [RD_LAT+1];
  logic [ADDR_W-1:0]   pl_addr_d [RD_LAT+1];
  logic [DATA_W-1:0]   pl_exp_q  [RD_LAT+1];
  logic [DATA_W-1:0]   pl_exp_d  [RD_LAT+1];

  always_comb begin
    state_d          = state_q;
    mode_d           = mode_q;
    iter_d           = iter_q;
    drain_cnt_d      = drain_cnt_q;
    ram_en_d         = ram_en_q;
    ram_we_d         = ram_we_q;
    ram_addr_d       = ram_addr_q;
    pass_d           = pass_q;
    err_cnt_d        = err_cnt_q;
    first_err_addr_d = first_err_addr_q;

    if (pl_v_q[RD_LAT] && (ram_rd_data != pl_exp_q[RD_LAT])) begin
      if (err_cnt_q == 16'd0) first_err_addr_d = pl_addr_q[RD_LAT];
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d          = S_WRITE;
          mode_d           = mode;
          iter_d           = '0;
          err_cnt_d        = '0;
          first_err_addr_d = '0;
          ram_en_d         = 1'b1;
          ram_we_d         = 1'b1;
          ram_addr_d       = '0;
        end else if ((state_q == S_DONE) && loop) begin
          state_d    = S_WRITE;
          iter_d     = iter_q + DATA_W'(1);
          ram_en_d   = 1'b1;
          ram_we_d   = 1'b1;
          ram_addr_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (ram_addr_q == LAST_ADDR) begin
          state_d    = S_READ;
          ram_we_d   = 1'b0;
          ram_addr_d = '0;
        end else begin
          ram_addr_d = ram_addr_q + ADDR_W'(1);
        end
      end
      S_READ: begin
        if (ram_addr_q == LAST_ADDR) begin
          state_d     = S_DRAIN;
          ram_en_d    = 1'b0;
          ram_addr_d  = '0;
          drain_cnt_d = DRAIN_LOAD;
        end else begin
          ram_addr_d = ram_addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == 3'd0) state_d = S_DONE;
        else drain_cnt_d = drain_cnt_q - 3'd1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    if (state_d == S_DONE) pass_d = (err_cnt_d == 16'd0);
    ram_wr_data_d = ram_we_d ? pattern(ram_addr_d, mode_d, iter_d) : '0;

    pl_v_d[0]    = ram_en_d & ~ram_we_d;
    pl_addr_d[0] = ram_addr_d;
    pl_exp_d[0]  = pattern(ram_addr_d, mode_d, iter_d);
    for (int i = 1; i <= RD_LAT; i++) begin
      pl_v_d[i]    = pl_v_q[i-1];
      pl_addr_d[i] = pl_addr_q[i-1];
      pl_exp_d[i]  = pl_exp_q[i-1];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q          <= S_IDLE;
      mode_q           <= '0;
      iter_q           <= '0;
      drain_cnt_q      <= '0;
      ram_en_q         <= 1'b0;
      ram_we_q         <= 1'b0;
      ram_addr_q       <= '0;
      ram_wr_data_q    <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
      pl_v_q           <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        pl_addr_q[i] <= '0;
        pl_exp_q[i]  <= '0;
      end
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      iter_q           <= iter_d;
      drain_cnt_q      <= drain_cnt_d;
      ram_en_q         <= ram_en_d;
      ram_we_q         <= ram_we_d;
      ram_addr_q       <= ram_addr_d;
      ram_wr_data_q    <= ram_wr_data_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      err_cnt_q        <= err_cnt_d;
      first_err_addr_q <= first_err_addr_d;
      pl_v_q           <= pl_v_d;
      for (int i = 0; i <= RD_LAT; i++) begin
        pl_addr_q[i] <= pl_addr_d[i];
        pl_exp_q[i]  <= pl_exp_d[i];
      end
    end
  end

  assign ram_en         = ram_en_q;
  assign ram_we         = ram_we_q;
  assign ram_addr       = ram_addr_q;
  assign ram_wr_data    = ram_wr_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: two geometries, behavioural RAMs with optional faults,
// a cycle-offset model of the whole run, and a few hand-computed literal checks.
module tb_ram_bist_ctrl;

  localparam int DW0 = 8,  AW0 = 5, D0 = 32,  L0 = 1;
  localparam int DW1 = 16, AW1 = 8, D1 = 256, L1 = 3;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic chk_en = 1'b0;
  int fault [2];

  always @(posedge sys_clk) cyc <= cyc + 1;

  logic start0, loop0, start1, loop1;
  logic [1:0] mode0, mode1;
  logic [DW0-1:0] rd0, wd0;
  logic [DW1-1:0] rd1, wd1;
  logic [AW0-1:0] addr0, fea0;
  logic [AW1-1:0] addr1, fea1;
  logic en0, we0, busy0, done0, pass0, en1, we1, busy1, done1, pass1;
  logic [15:0] ec0, ec1;

  ram_bist_ctrl #(.DATA_W(DW0), .ADDR_W(AW0), .DEPTH(D0), .RD_LAT(L0)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start0), .mode(mode0), .loop(loop0),
    .ram_rd_data(rd0), .ram_en(en0), .ram_we(we0), .ram_addr(addr0), .ram_wr_data(wd0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(ec0), .first_err_addr(fea0));

  ram_bist_ctrl #(.DATA_W(DW1), .ADDR_W(AW1), .DEPTH(D1), .RD_LAT(L1)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start1), .mode(mode1), .loop(loop1),
    .ram_rd_data(rd1), .ram_en(en1), .ram_we(we1), .ram_addr(addr1), .ram_wr_data(wd1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(ec1), .first_err_addr(fea1));

  function automatic int dep(input int i);  return (i == 0) ? D0 : D1;  endfunction
  function automatic int lat(input int i);  return (i == 0) ? L0 : L1;  endfunction
  function automatic int mask(input int i); return (i == 0) ? 32'hFF : 32'hFFFF; endfunction

  function automatic int pat(input int i, input int a, input int m, input int it);
    case (m)
      0:       return a & mask(i);
      1:       return ~a & mask(i);
      2:       return ((a % 2) == 1) ? (32'hAAAA_AAAA & mask(i)) : (32'h5555_5555 & mask(i));
      default: return (a + it) & mask(i);
    endcase
  endfunction

  // Fault 1: bit 0 flipped on reads of address 5. Fault 2: bit 7 stuck at 0.
  function automatic int corrupt(input int i, input int a, input int v);
    case (fault[i])
      1:       return (a == 5) ? (v ^ 1) : v;
      2:       return v & ~32'h80;
      default: return v;
    endcase
  endfunction

  // Behavioural RAMs: the read word appears RD_LAT edges after the address is sampled.
  logic [DW0-1:0] mem0 [D0];
  logic [DW0-1:0] rp0  [L0];
  logic [DW1-1:0] mem1 [D1];
  logic [DW1-1:0] rp1  [L1];

  always @(posedge sys_clk) begin
    if (en0 && we0) mem0[addr0] <= wd0;
    rp0[0] <= DW0'(corrupt(0, int'(addr0), int'(mem0[addr0])));
    for (int j = 1; j < L0; j++) rp0[j] <= rp0[j-1];
  end
  assign rd0 = rp0[L0-1];

  always @(posedge sys_clk) begin
    if (en1 && we1) mem1[addr1] <= wd1;
    rp1[0] <= DW1'(corrupt(1, int'(addr1), int'(mem1[addr1])));
    for (int j = 1; j < L1; j++) rp1[j] <= rp1[j-1];
  end
  assign rd1 = rp1[L1-1];

  int i_start [2], i_loop [2], i_mode [2];
  int o_en [2], o_we [2], o_addr [2], o_wd [2], o_busy [2], o_done [2], o_pass [2], o_ec [2], o_fea [2];
  always_comb begin
    i_start[0] = int'(start0); i_loop[0] = int'(loop0); i_mode[0] = int'(mode0);
    i_start[1] = int'(start1); i_loop[1] = int'(loop1); i_mode[1] = int'(mode1);
    o_en[0] = int'(en0); o_we[0] = int'(we0); o_addr[0] = int'(addr0); o_wd[0] = int'(wd0);
    o_busy[0] = int'(busy0); o_done[0] = int'(done0); o_pass[0] = int'(pass0);
    o_ec[0] = int'(ec0); o_fea[0] = int'(fea0);
    o_en[1] = int'(en1); o_we[1] = int'(we1); o_addr[1] = int'(addr1); o_wd[1] = int'(wd1);
    o_busy[1] = int'(busy1); o_done[1] = int'(done1); o_pass[1] = int'(pass1);
    o_ec[1] = int'(ec1); o_fea[1] = int'(fea1);
  end

  // Model: t = edges since the accepted start (-1 when idle); everything follows from t.
  typedef struct {
    int t; int mode; int iter; int err; int fea; int pass;
  } mstate_t;
  mstate_t ms [2];

  function automatic mstate_t step(input int i, input mstate_t c);
    mstate_t n;
    int dt, k, e;
    n  = c;
    dt = 2 * dep(i) + lat(i) + 1;
    if (c.t < 0 || c.t == dt) begin
      if (i_start[i] != 0) begin
        n.t = 0; n.mode = i_mode[i]; n.iter = 0; n.err = 0; n.fea = 0;
      end else if (c.t == dt && i_loop[i] != 0) begin
        n.t = 0; n.iter = (c.iter + 1) & mask(i);
      end else begin
        n.t = -1;
      end
    end else begin
      n.t = c.t + 1;
    end
    k = n.t - dep(i) - 1 - lat(i);
    if (n.t >= 0 && k >= 0 && k < dep(i)) begin
      e = pat(i, k, n.mode, n.iter);
      if (corrupt(i, k, e) != e) begin
        if (n.err == 0) n.fea = k;
        if (n.err < 65535) n.err = n.err + 1;
      end
    end
    if (n.t == dt) n.pass = (n.err == 0) ? 1 : 0;
    return n;
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 2; i++) ms[i] <= '{t: -1, default: 0};
    end else begin
      for (int i = 0; i < 2; i++) ms[i] <= step(i, ms[i]);
    end
  end

  task automatic chk(input int i, input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[dut%0d] at %0t: got %0d expected %0d", nm, i, $time, act, exp);
    end
  endtask

  task automatic cmp_cycle(input int i);
    int t, d, l;
    t = ms[i].t; d = dep(i); l = lat(i);
    chk(i, "ram_en",  o_en[i],   (t >= 0 && t < 2 * d) ? 1 : 0);
    chk(i, "ram_we",  o_we[i],   (t >= 0 && t < d) ? 1 : 0);
    chk(i, "ram_addr", o_addr[i], (t >= 0 && t < d) ? t : ((t >= d && t < 2 * d) ? t - d : 0));
    chk(i, "busy",    o_busy[i], (t >= 0 && t <= 2 * d + l) ? 1 : 0);
    chk(i, "done",    o_done[i], (t == 2 * d + l + 1) ? 1 : 0);
    chk(i, "pass",    o_pass[i], ms[i].pass);
    chk(i, "err_cnt", o_ec[i],   ms[i].err);
    if (t >= 0 && t < d) chk(i, "wr_data", o_wd[i], pat(i, t, ms[i].mode, ms[i].iter));
    if (ms[i].err != 0) chk(i, "first_err_addr", o_fea[i], ms[i].fea);
  endtask

  always @(negedge sys_clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) cmp_cycle(i);
    end
  end

  task automatic go(input int i, input int m, input int lp, output int s);
    @(negedge sys_clk);
    if (i == 0) begin start0 = 1'b1; mode0 = 2'(m); loop0 = lp[0]; end
    else        begin start1 = 1'b1; mode1 = 2'(m); loop1 = lp[0]; end
    @(negedge sys_clk);
    if (i == 0) start0 = 1'b0; else start1 = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int i, input int lim, output int at);
    at = -1;
    for (int n = 0; n < lim; n++) begin
      @(negedge sys_clk);
      if (o_done[i] == 1) begin
        at = cyc;
        break;
      end
    end
    chk(i, "done_seen", (at >= 0) ? 1 : 0, 1);
  endtask

  initial begin
    int s, at, a1, a2, a3, n;
    sys_rst_n = 1'b1;
    start0 = 1'b0; loop0 = 1'b0; mode0 = 2'd0;
    start1 = 1'b0; loop1 = 1'b0; mode1 = 2'd0;
    fault[0] = 0; fault[1] = 0;
    #2 sys_rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk(0, "rst_busy", o_busy[0], 0);
    chk(1, "rst_err_cnt", o_ec[1], 0);
    #1 sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Mode 0, clean RAM.
    go(0, 0, 0, s);
    wait_done(0, 200, at);
    chk(0, "done_latency", at - s, 66);
    chk(0, "clean_pass", o_pass[0], 1);
    chk(0, "clean_err", o_ec[0], 0);
    @(negedge sys_clk);
    chk(0, "idle_busy", o_busy[0], 0);

    // Mode 1, address 5 read bit 0 flipped.
    fault[0] = 1;
    go(0, 1, 0, s);
    wait_done(0, 200, at);
    chk(0, "flip_err", o_ec[0], 1);
    chk(0, "flip_addr", o_fea[0], 5);
    chk(0, "flip_pass", o_pass[0], 0);

    // Mode 2, bit 7 stuck at 0: every odd address (0xAA) fails.
    fault[0] = 2;
    go(0, 2, 0, s);
    wait_done(0, 200, at);
    chk(0, "stuck_err", o_ec[0], 16);
    chk(0, "stuck_addr", o_fea[0], 1);
    chk(0, "stuck_pass", o_pass[0], 0);
    fault[0] = 0;

    // Wide geometry, mode 3, three looped iterations.
    go(1, 3, 1, s);
    wait_done(1, 2000, a1);
    repeat (8) @(negedge sys_clk);
    chk(1, "it2_addr", o_addr[1], 7);
    chk(1, "it2_wr_data", o_wd[1], 8);
    wait_done(1, 2000, a2);
    @(negedge sys_clk);
    chk(1, "it3_wr_data0", o_wd[1], 2);
    loop1 = 1'b0;
    wait_done(1, 2000, a3);
    chk(1, "loop_period1", a2 - a1, 517);
    chk(1, "loop_period2", a3 - a2, 517);
    chk(1, "loop_pass", o_pass[1], 1);
    repeat (5) @(negedge sys_clk);
    chk(1, "loop_idle", o_busy[1], 0);

    // Reset mid-READ at address 10, then a clean rerun.
    go(0, 0, 0, s);
    n = 0;
    while (!(o_en[0] == 1 && o_we[0] == 0 && o_addr[0] == 10) && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    chk(0, "reach_rd10", (n < 200) ? 1 : 0, 1);
    #1 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk(0, "midrst_en", o_en[0], 0);
    chk(0, "midrst_addr", o_addr[0], 0);
    chk(0, "midrst_done", o_done[0], 0);
    #1 sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    go(0, 0, 0, s);
    wait_done(0, 200, at);
    chk(0, "rerun_latency", at - s, 66);
    chk(0, "rerun_pass", o_pass[0], 1);

    // start hammered while busy must not restart the run.
    go(0, 1, 0, s);
    for (int j = 0; j < 60; j++) begin
      @(negedge sys_clk);
      start0 = ((j % 3) == 0);
    end
    start0 = 1'b0;
    wait_done(0, 200, at);
    chk(0, "busy_start_latency", at - s, 66);
    chk(0, "busy_start_pass", o_pass[0], 1);

    repeat (3) @(negedge sys_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
